// File: rtl/md_issue_ctrl.sv
// Issue control for the HI/LO multiply/divide unit: launches operations, tracks their run time and stalls D.
// Optional MD_CHECK_EN adds a sticky protocol checker on md_err.
module md_issue_ctrl #(
   parameter int unsigned MULT_LAT = 5,
   parameter int unsigned DIV_LAT  = 10
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       e_valid,
   input  logic       e_md_start,
   input  logic [1:0] e_md_op,
   input  logic [1:0] e_mt,
   input  logic       d_md_use,
   input  logic       exc_in,
   input  logic       md_busy,
   output logic       Start,
   output logic [1:0] opsrc,
   output logic [1:0] wsrc,
   output logic       stall_D,
   output logic       md_state,
   output logic       md_err
);

   localparam int unsigned CNT_W = 4;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               run;

   assign run      = (state_q == RUN);
   assign md_state = run;

   // Issue decode; wsrc and Start are mutually exclusive through e_md_start.
   always_comb begin
      Start   = e_valid & e_md_start & ~exc_in & Reset;
      opsrc   = Start ? e_md_op : 2'b00;
      wsrc    = (e_valid & ~exc_in & ~e_md_start & Reset) ? e_mt : 2'b00;
      stall_D = d_md_use & (Start | run);
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (Start) begin
               state_d = RUN;
               cnt_d   = e_md_op[1] ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
            end
         end
         RUN: begin
            // A Start seen here is a protocol violation and does not reload the count.
            if (exc_in || (cnt_q == CNT_W'(1))) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d   = cnt_q - CNT_W'(1);
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef MD_CHECK_EN
   logic md_err_q, md_err_d;

   // Flags a busy/state disagreement with the MD unit or a launch into a running unit.
   always_comb begin
      md_err_d = md_err_q | (md_busy != run) | (Start & run);
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         md_err_q <= 1'b0;
      end else begin
         md_err_q <= md_err_d;
      end
   end

   assign md_err = md_err_q;
`else
   logic unused_md_busy;

   assign unused_md_busy = md_busy;
   assign md_err         = 1'b0;
`endif

endmodule

// File: tb/tb_md_issue_ctrl.sv
// Bench for md_issue_ctrl: directed scenarios plus random stimulus against a timestamp-based model.
module tb_md_issue_ctrl;

   localparam int unsigned MULT_LAT = 5;
   localparam int unsigned DIV_LAT  = 10;
`ifdef MD_CHECK_EN
   localparam bit CHK = 1'b1;
`else
   localparam bit CHK = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       e_valid = 1'b0, e_md_start = 1'b0, d_md_use = 1'b0, exc_in = 1'b0, md_busy = 1'b0;
   logic [1:0] e_md_op = 2'b00, e_mt = 2'b00;
   logic       Start, stall_D, md_state, md_err;
   logic [1:0] opsrc, wsrc;

   int total = 0;
   int bad   = 0;

   // Model: the unit is running in cycle c iff c < run_end.
   int cyc      = 0;
   int run_end  = 0;
   bit err_m    = 1'b0;
   bit busy_bad = 1'b0;

   md_issue_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT)) dut (
      .Clk(Clk), .Reset(Reset), .e_valid(e_valid), .e_md_start(e_md_start),
      .e_md_op(e_md_op), .e_mt(e_mt), .d_md_use(d_md_use), .exc_in(exc_in),
      .md_busy(md_busy), .Start(Start), .opsrc(opsrc), .wsrc(wsrc),
      .stall_D(stall_D), .md_state(md_state), .md_err(md_err)
   );

   always #5 Clk = ~Clk;

   function automatic bit m_run();
      return (cyc < run_end);
   endfunction

   task automatic set_in(input bit v, input bit st, input logic [1:0] op,
                         input logic [1:0] mt, input bit du, input bit ex);
      e_valid = v; e_md_start = st; e_md_op = op; e_mt = mt; d_md_use = du; exc_in = ex;
      #1;
   endtask

   // Advance one clock, updating the model from the inputs seen at the edge.
   task automatic tick();
      bit run, st;
      run = m_run();
      st  = e_valid & e_md_start & ~exc_in;
      md_busy = busy_bad ? 1'b0 : run;
      if (CHK) err_m = err_m | (md_busy != run) | (st & run);
      if (run && exc_in) run_end = cyc + 1;
      else if (!run && st) run_end = cyc + 1 + int'(e_md_op[1] ? DIV_LAT : MULT_LAT);
      @(posedge Clk);
      cyc++;
      #1;
   endtask

   task automatic do_reset();
      set_in(0, 0, 2'b00, 2'b00, 0, 0);
      busy_bad = 1'b0;
      md_busy = 1'b0;
      Reset = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b1;
      run_end = 0; err_m = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      set_in(1, 1, 2'b10, 2'b00, 1, 0);
      total++; if (Start !== 1'b0) begin bad++; $display("FAIL reset_start got=%b exp=0", Start); end
      total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall_D); end
      total++; if (md_state !== 1'b0) begin bad++; $display("FAIL reset_state got=%b exp=0", md_state); end
      total++; if (md_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", md_err); end
      set_in(1, 0, 2'b00, 2'b01, 0, 0);
      total++; if (wsrc !== 2'b00) begin bad++; $display("FAIL reset_wsrc got=%0d exp=0", wsrc); end
      do_reset();
   endtask

   // mult at cycle 0, dependent in D 0..6: stall 0..5, released at 6.
   task automatic test_mult();
      do_reset();
      for (int k = 0; k <= 6; k++) begin
         set_in(k == 0, k == 0, 2'b00, 2'b00, 1, 0);
         total++; if (Start !== (k == 0)) begin bad++; $display("FAIL mult_start k=%0d got=%b exp=%b", k, Start, k == 0); end
         total++; if (stall_D !== (k <= 5)) begin bad++; $display("FAIL mult_stall k=%0d got=%b exp=%b", k, stall_D, k <= 5); end
         total++; if (md_state !== (k >= 1 && k <= 5)) begin bad++; $display("FAIL mult_state k=%0d got=%b", k, md_state); end
         tick();
      end
   endtask

   // divu then mflo: stall 0..10, state back to IDLE at 11.
   task automatic test_divu();
      do_reset();
      for (int k = 0; k <= 11; k++) begin
         set_in(k == 0, k == 0, 2'b11, 2'b00, 1, 0);
         if (k == 0) begin
            total++; if (opsrc !== 2'b11) begin bad++; $display("FAIL divu_opsrc got=%0d exp=3", opsrc); end
         end
         total++; if (stall_D !== (k <= 10)) begin bad++; $display("FAIL divu_stall k=%0d got=%b exp=%b", k, stall_D, k <= 10); end
         total++; if (md_state !== (k >= 1 && k <= 10)) begin bad++; $display("FAIL divu_state k=%0d got=%b", k, md_state); end
         tick();
      end
      total++; if (md_err !== 1'b0) begin bad++; $display("FAIL divu_err got=%b exp=0", md_err); end
   endtask

   // div aborted by an exception at count 4 (cycle 7).
   task automatic test_exc_abort();
      do_reset();
      for (int k = 0; k <= 8; k++) begin
         set_in(k == 0, k == 0, 2'b10, 2'b00, 1, k == 7);
         if (k == 7) begin
            total++; if (md_state !== 1'b1) begin bad++; $display("FAIL exc_pre_state got=%b exp=1", md_state); end
         end
         if (k == 8) begin
            total++; if (md_state !== 1'b0) begin bad++; $display("FAIL exc_state got=%b exp=0", md_state); end
            total++; if (stall_D !== 1'b0) begin bad++; $display("FAIL exc_stall got=%b exp=0", stall_D); end
            total++; if (md_err !== 1'b0) begin bad++; $display("FAIL exc_err got=%b exp=0", md_err); end
         end
         tick();
      end
   endtask

   task automatic test_move_to();
      do_reset();
      set_in(1, 0, 2'b00, 2'b01, 0, 0);
      total++; if (wsrc !== 2'b01 || Start !== 1'b0) begin bad++; $display("FAIL mthi got wsrc=%0d start=%b exp 1/0", wsrc, Start); end
      set_in(1, 0, 2'b00, 2'b01, 0, 1);
      total++; if (wsrc !== 2'b00) begin bad++; $display("FAIL mthi_exc wsrc got=%0d exp=0", wsrc); end
      set_in(1, 0, 2'b00, 2'b10, 0, 0);
      total++; if (wsrc !== 2'b10) begin bad++; $display("FAIL mtlo wsrc got=%0d exp=2", wsrc); end
      set_in(0, 1, 2'b01, 2'b10, 1, 0);
      total++; if (Start !== 1'b0 || wsrc !== 2'b00 || opsrc !== 2'b00) begin bad++; $display("FAIL bubble got start=%b wsrc=%0d opsrc=%0d exp 0", Start, wsrc, opsrc); end
      set_in(1, 1, 2'b01, 2'b00, 1, 1);
      total++; if (Start !== 1'b0 || stall_D !== 1'b0) begin bad++; $display("FAIL issue_exc got start=%b stall=%b exp 0/0", Start, stall_D); end
      tick();
      total++; if (md_state !== 1'b0) begin bad++; $display("FAIL issue_exc_state got=%b exp=0", md_state); end
   endtask

   // Reset mid-mult, then a clean multu.
   task automatic test_reset_mid();
      do_reset();
      for (int k = 0; k < 3; k++) begin
         set_in(k == 0, k == 0, 2'b00, 2'b00, 1, 0);
         tick();
      end
      set_in(0, 0, 2'b00, 2'b00, 1, 0);
      total++; if (stall_D !== 1'b1) begin bad++; $display("FAIL rmid_pre_stall got=%b exp=1", stall_D); end
      #2; Reset = 1'b0; #1;
      run_end = 0; err_m = 1'b0;
      total++; if (md_state !== 1'b0 || stall_D !== 1'b0) begin bad++; $display("FAIL rmid_async got state=%b stall=%b exp 0/0", md_state, stall_D); end
      @(posedge Clk); #1; cyc++;
      Reset = 1'b1;
      for (int k = 0; k <= 6; k++) begin
         set_in(k == 0, k == 0, 2'b01, 2'b00, 0, 0);
         total++; if (md_state !== (k >= 1 && k <= 5)) begin bad++; $display("FAIL rmid_multu k=%0d got=%b", k, md_state); end
         tick();
      end
   endtask

   // Busy held low during RUN: sticky error only with the checker built in.
   task automatic test_busy_err();
      do_reset();
      busy_bad = 1'b1;
      for (int k = 0; k <= 8; k++) begin
         set_in(k == 0, k == 0, 2'b00, 2'b00, 0, 0);
         total++; if (md_err !== (CHK && k >= 2)) begin bad++; $display("FAIL busy_err k=%0d got=%b exp=%b", k, md_err, CHK && k >= 2); end
         tick();
      end
      do_reset();
      total++; if (md_err !== 1'b0) begin bad++; $display("FAIL busy_err_clear got=%b exp=0", md_err); end
   endtask

   task automatic test_random();
      bit v, st, ex, du, se, run;
      logic [1:0] op, mt, we;
      do_reset();
      for (int k = 0; k < 400; k++) begin
         v  = ($urandom_range(0, 3) != 0);
         st = ($urandom_range(0, 3) == 0);
         ex = ($urandom_range(0, 11) == 0);
         du = $urandom_range(0, 1);
         op = 2'($urandom_range(0, 3));
         mt = 2'($urandom_range(0, 2));
         set_in(v, st, op, mt, du, ex);
         run = m_run();
         se  = v & st & ~ex;
         we  = (v & ~ex & ~st) ? mt : 2'b00;
         total++; if (Start !== se) begin bad++; $display("FAIL rnd_start k=%0d got=%b exp=%b", k, Start, se); end
         total++; if (opsrc !== (se ? op : 2'b00)) begin bad++; $display("FAIL rnd_opsrc k=%0d got=%0d", k, opsrc); end
         total++; if (wsrc !== we) begin bad++; $display("FAIL rnd_wsrc k=%0d got=%0d exp=%0d", k, wsrc, we); end
         total++; if (stall_D !== (du & (se | run))) begin bad++; $display("FAIL rnd_stall k=%0d got=%b exp=%b", k, stall_D, du & (se | run)); end
         total++; if (md_state !== run) begin bad++; $display("FAIL rnd_state k=%0d got=%b exp=%b", k, md_state, run); end
         total++; if (md_err !== err_m) begin bad++; $display("FAIL rnd_err k=%0d got=%b exp=%b", k, md_err, err_m); end
         tick();
      end
   endtask

   initial begin
      #2;
      test_reset();
      test_mult();
      test_divu();
      test_exc_abort();
      test_move_to();
      test_reset_mid();
      test_busy_err();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
